// File: rtl/data_mem_mmio.sv
// Data RAM plus a small MMIO block (console TX FIFO, status, cycle counter) on one CPU data port.
// Loads are combinational; stores, FIFO pushes/pops and the counter update on the rising clock edge.
module data_mem_mmio #(
    parameter int          MEM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0001_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        re_i,
    input  logic        we_i,
    output logic [31:0] rdata_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        bus_err_o
);
    localparam int          AW        = $clog2(MEM_WORDS);
    localparam int          FW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [FW:0] FULL_CNT  = (FW + 1)'(FIFO_DEPTH);

    logic [31:0]   ram [MEM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr_reg;
    logic [FW-1:0] rd_ptr_reg;
    logic [FW:0]   count_reg;
    logic          overflow_reg;
    logic          bus_err_reg;
    logic [31:0]   cycle_reg;

    logic        access, is_ram, is_tx, is_stat, is_cyc, mapped, err;
    logic        full, empty, push, pop, push_ok, ovf_set, ovf_clr, ram_we;
    logic [AW-1:0] word_idx;

    // Address decode and error classification
    always_comb begin
        access  = re_i | we_i;
        is_ram  = addr_i < RAM_BYTES;
        is_tx   = addr_i == MMIO_BASE;
        is_stat = addr_i == MMIO_BASE + 32'd4;
        is_cyc  = addr_i == MMIO_BASE + 32'd8;
        mapped  = is_ram | is_tx | is_stat | is_cyc;
        err     = access & ((addr_i[1:0] != 2'b00)
                          | !mapped
                          | (we_i & is_stat & !wdata_i[3])
                          | (we_i & is_cyc)
                          | (re_i & we_i));
        word_idx = addr_i[AW+1:2];
    end

    always_comb begin
        full    = count_reg == FULL_CNT;
        empty   = count_reg == '0;
        pop     = reset_i & !empty & tx_ready_i;
        push    = reset_i & we_i & !err & is_tx;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        push_ok = push & (!full | pop);
        ovf_set = push & full & !pop;
        ovf_clr = reset_i & we_i & !err & is_stat & wdata_i[3];
        ram_we  = reset_i & we_i & !err & is_ram;
    end

    always_comb begin
        rdata_o = '0;
        if (re_i && !err) begin
            if (is_ram)
                rdata_o = ram[word_idx];
            else if (is_stat)
                rdata_o = {28'b0, overflow_reg, full, empty, 1'b0};
            else if (is_cyc)
                rdata_o = cycle_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we)
            ram[word_idx] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= wdata_i[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            bus_err_reg  <= 1'b0;
            cycle_reg    <= '0;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (ovf_set)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
            if (err)
                bus_err_reg <= 1'b1;
        end
    end

    assign tx_valid_o = !empty;
    assign tx_data_o  = fifo_mem[rd_ptr_reg];
    assign bus_err_o  = bus_err_reg;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: expected load data and TX bytes are queued at stimulus
// time and compared when the DUT presents them.
module tb_data_mem_mmio;
    localparam logic [31:0] BASE    = 32'h0001_0000;
    localparam logic [31:0] A_TX    = BASE;
    localparam logic [31:0] A_STAT  = BASE + 32'd4;
    localparam logic [31:0] A_CYC   = BASE + 32'd8;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        re_i;
    logic        we_i;
    logic [31:0] rdata_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        bus_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rd_q[$];
    string       rd_tag_q[$];
    logic [7:0]  tx_q[$];

    data_mem_mmio #(.MEM_WORDS(256), .FIFO_DEPTH(8), .MMIO_BASE(BASE)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .re_i(re_i), .we_i(we_i), .rdata_o(rdata_o), .tx_valid_o(tx_valid_o),
        .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        addr_i = a; wdata_i = d; we_i = 1'b1;
        step();
        we_i = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input string tag);
        addr_i = a; re_i = 1'b1;
        rd_q.push_back(exp);
        rd_tag_q.push_back(tag);
        @(negedge clk_i);
        check_eq(rd_tag_q.pop_front(), rdata_o, rd_q.pop_front());
        step();
        re_i = 1'b0;
    endtask

    task automatic do_both(input logic [31:0] a, input logic [31:0] d, input string tag);
        addr_i = a; wdata_i = d; re_i = 1'b1; we_i = 1'b1;
        rd_q.push_back(32'h0);
        rd_tag_q.push_back(tag);
        @(negedge clk_i);
        check_eq(rd_tag_q.pop_front(), rdata_o, rd_q.pop_front());
        step();
        re_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        step();
        reset_i = 1'b1;
        tx_q.delete();
    endtask

    task automatic drain(input string tag);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 40 && tx_valid_o; i++)
            step();
        tx_ready_i = 1'b0;
        check_eq({tag, "_valid_low"}, {31'b0, tx_valid_o}, 32'd0);
        check_eq({tag, "_all_seen"}, 32'(tx_q.size()), 32'd0);
    endtask

    // Pop side of the TX scoreboard: a byte leaves at the next edge when valid and ready
    always @(negedge clk_i) begin
        if (reset_i === 1'b1 && tx_valid_o && tx_ready_i) begin
            if (tx_q.size() == 0)
                check_eq("tx_spurious", 32'(tx_q.size()), 32'd1);
            else
                check_eq("tx_byte", {24'b0, tx_data_o}, {24'b0, tx_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b0; re_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; tx_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b1;

        // Reset state
        do_load(A_CYC, 32'd0, "rst_cycle");
        check_eq("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        check_eq("rst_bus_err", {31'b0, bus_err_o}, 32'd0);
        do_load(A_STAT, 32'h2, "rst_status");

        // RAM store / load
        do_store(32'h10, 32'hDEAD_BEEF);
        do_load(32'h10, 32'hDEAD_BEEF, "ram_rd_10");
        addr_i = 32'h14; re_i = 1'b1;
        step();
        re_i = 1'b0;
        check_eq("ram_rd_14_no_err", {31'b0, bus_err_o}, 32'd0);
        do_store(32'h20, 32'h1234_5678);
        do_load(32'h20, 32'h1234_5678, "ram_rd_20");
        do_load(A_TX, 32'h0, "tx_data_read_zero");

        // Fill FIFO with sink stalled, then overflow
        for (int i = 1; i <= 9; i++) begin
            do_store(A_TX, 32'(i));
            if (i <= 8) tx_q.push_back(8'(i));
            if (i == 8) do_load(A_STAT, 32'h4, "status_full");
        end
        do_load(A_STAT, 32'hC, "status_full_ovf");
        drain("drain1");
        do_load(A_STAT, 32'hA, "status_empty_ovf");

        // Clear overflow
        do_store(A_STAT, 32'h8);
        do_load(A_STAT, 32'h2, "status_ovf_clr");
        check_eq("ovf_clr_no_err", {31'b0, bus_err_o}, 32'd0);

        // Push while full with a simultaneous pop
        for (int i = 0; i < 8; i++) begin
            do_store(A_TX, 32'h11 + 32'(i));
            tx_q.push_back(8'h11 + 8'(i));
        end
        tx_ready_i = 1'b1;
        tx_q.push_back(8'hAA);
        do_store(A_TX, 32'hAA);
        tx_ready_i = 1'b0;
        do_load(A_STAT, 32'h4, "full_push_pop");
        drain("drain2");

        // Reset mid-operation discards FIFO, blocks RAM store, restarts CYCLE
        for (int i = 0; i < 3; i++)
            do_store(A_TX, 32'h31 + 32'(i));
        addr_i = 32'h20; wdata_i = 32'hFFFF_0000; we_i = 1'b1;
        do_reset();
        we_i = 1'b0;
        check_eq("mid_rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        do_load(A_CYC, 32'd0, "cycle_restart");
        repeat (9) step();
        do_load(A_CYC, 32'd10, "cycle_plus10");
        do_load(A_STAT, 32'h2, "mid_rst_status");
        do_load(32'h20, 32'h1234_5678, "ram_no_write_in_rst");
        do_load(32'h10, 32'hDEAD_BEEF, "ram_survives_rst");

        // Counter wrap
        force dut.cycle_reg = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_reg;
        do_load(A_CYC, 32'hFFFF_FFFE, "cycle_near_max");
        do_load(A_CYC, 32'hFFFF_FFFF, "cycle_max");
        do_load(A_CYC, 32'h0, "cycle_wrap");

        // Access errors, each from a clean reset
        do_reset();
        check_eq("err_pre", {31'b0, bus_err_o}, 32'd0);
        do_load(32'h2, 32'h0, "ld_misalign_rdata");
        check_eq("err_ld_misalign", {31'b0, bus_err_o}, 32'd1);
        step();
        check_eq("err_sticky", {31'b0, bus_err_o}, 32'd1);

        do_reset();
        check_eq("err_cleared_by_rst", {31'b0, bus_err_o}, 32'd0);
        do_store(32'h0002_0000, 32'h1);
        check_eq("err_unmapped_st", {31'b0, bus_err_o}, 32'd1);

        do_reset();
        do_both(32'h10, 32'h1111_1111, "re_we_rdata");
        check_eq("err_re_we", {31'b0, bus_err_o}, 32'd1);

        do_reset();
        do_store(32'h11, 32'h2222_2222);
        check_eq("err_st_misalign", {31'b0, bus_err_o}, 32'd1);
        do_load(32'h10, 32'hDEAD_BEEF, "ram_unchanged_by_err");

        do_reset();
        do_store(A_STAT, 32'h4);
        check_eq("err_st_status", {31'b0, bus_err_o}, 32'd1);

        do_reset();
        do_store(A_CYC, 32'h0);
        check_eq("err_st_cycle", {31'b0, bus_err_o}, 32'd1);

        do_reset();
        do_store(32'h0001_000C, 32'h55);
        check_eq("err_unmapped_mmio", {31'b0, bus_err_o}, 32'd1);
        check_eq("err_no_push", {31'b0, tx_valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 Parameter MEM_WORDS, 256, number of 32-bit data RAM words (power of two, 16..4096).
REQ-002 Parameter FIFO_DEPTH, 8, console TX FIFO entries (power of two, 2..64).
REQ-003 Parameter MMIO_BASE, 32'h0001_0000, base byte address of the MMIO register block.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-low reset; sampled on the rising edge of clk_i.
REQ-006 addr_i  input  32  byte address from the CPU data port.
REQ-007 wdata_i  input  32  store data.
REQ-008 re_i  input  1  load strobe.
REQ-009 we_i  input  1  store strobe.
REQ-010 rdata_o  output  32  load data, combinational from addr_i/re_i in the same cycle.
REQ-011 tx_valid_o  output  1  FIFO head valid.
REQ-012 tx_data_o  output  8  FIFO head byte.
REQ-013 tx_ready_i  input  1  sink accepts the head byte.
REQ-014 bus_err_o  output  1  sticky access-error flag.

Function
REQ-015 Address decode SHALL be: RAM = addr_i < MEM_WORDS*4; TX_DATA = MMIO_BASE+0; STATUS = MMIO_BASE+4; CYCLE = MMIO_BASE+8; any other address is unmapped.
REQ-016 A RAM store SHALL write wdata_i to word addr_i[log2(MEM_WORDS)+1:2] at the clock edge while we_i=1; a RAM load SHALL return that word combinationally (a write and a read of the same word in one cycle return the old value).
REQ-017 rdata_o SHALL be 0 whenever re_i=0, the access is an error, or a write-only register is read.
REQ-018 An access error SHALL be: re_i or we_i high with addr_i[1:0]!=0, an unmapped address, a store to STATUS or CYCLE other than the clear defined in REQ-022, or re_i and we_i both high; an error access SHALL perform no write and no FIFO push, and SHALL set bus_err_o at the next edge.
REQ-019 A store to TX_DATA SHALL push wdata_i[7:0]; when the FIFO is full and no pop occurs in the same cycle, the byte SHALL be dropped and the overflow flag set.
REQ-020 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full (push accepted) and when it holds one entry; when empty, a push SHALL NOT pop and tx_valid_o SHALL rise on the edge after the push.
REQ-021 A pop SHALL occur when tx_valid_o and tx_ready_i are both 1 at an edge; tx_valid_o = (count != 0); tx_data_o = head entry, stable while tx_valid_o=1 and tx_ready_i=0.
REQ-022 STATUS read SHALL return {28'b0, overflow, full, empty, 1'b0} in bits [3:0]; a store to STATUS with wdata_i[3]=1 SHALL clear overflow; any other STATUS store is an error.
REQ-023 CYCLE SHALL be a 32-bit counter incremented every non-reset cycle, wrapping from 32'hFFFF_FFFF to 0; a read SHALL return the current pre-increment value.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count SHALL range 0..FIFO_DEPTH; full = (count == FIFO_DEPTH).
REQ-025 bus_err_o and overflow SHALL remain set until reset; overflow SHALL also clear by REQ-022.

Reset
REQ-026 With reset_i=0 at an edge: FIFO pointers and count = 0, overflow = 0, bus_err_o = 0, CYCLE = 0; tx_valid_o = 0 after that edge.
REQ-027 Reset mid-operation SHALL discard all FIFO contents; RAM contents are not reset and SHALL NOT be written during reset.
REQ-028 Stores and pushes presented while reset_i=0 SHALL be ignored.

Verification
REQ-029 Store 32'hDEAD_BEEF to 0x0000_0010, then load 0x0000_0010 -> rdata_o = 32'hDEAD_BEEF; load 0x0000_0014 after reset (no prior store) -> value unchecked, bus_err_o = 0.
REQ-030 Hold tx_ready_i=0 and push bytes 0x01..0x09 -> after the 8th push STATUS = 4'b0100 (full); the 9th push is dropped and STATUS = 4'b1100; draining returns 0x01..0x08 in order, then tx_valid_o = 0.
REQ-031 FIFO full with tx_ready_i=1 and a push of 0xAA in the same cycle -> count stays 8, no overflow, 0xAA emerges last.
REQ-032 Load 0x0000_0002, store to 0x0002_0000, and re_i=we_i=1 -> each yields rdata_o = 0, no state change, and bus_err_o = 1 from the next edge until reset.
REQ-033 Read CYCLE, wait 10 cycles, read again -> difference = 10; force the counter near 32'hFFFF_FFFF -> it wraps to 0.
REQ-034 Assert reset_i=0 for one cycle with 3 bytes queued -> tx_valid_o = 0, STATUS = 4'b0010 (empty), CYCLE restarts at 0.
